// File: rtl/ecc_pkg.sv
// Shared types and helpers for the ECC request scheduler.
// The arbitration rule lives here so the arbiter and any future user agree on it.
package ecc_pkg;
  localparam int OPW     = 163;
  localparam int RESW    = 176;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Rotating priority: first set bit strictly after ptr, wrapping at n. -1 when none.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    int win;
    int idx;
    win = -1;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = (ptr + i) % n;
      if (i <= n && win < 0 && req[3'(idx)]) win = idx;
    end
    return win;
  endfunction
endpackage

// File: rtl/ecc_req_scheduler_if.sv
// Requester, response and core-side signals of the ECC request scheduler.
// slave = scheduler view, master = the environment around it.
interface ecc_req_scheduler_if import ecc_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*OPW-1:0] req_g;
  logic [NUM_REQ*OPW-1:0] req_k;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [RESW-1:0]        rsp_x;
  logic [RESW-1:0]        rsp_z;
  logic                   rsp_err;
  logic                   ecc_start;
  logic [OPW-1:0]         ecc_g;
  logic [OPW-1:0]         ecc_k;
  logic [RESW-1:0]        ecc_outxa;
  logic [RESW-1:0]        ecc_outza;
  logic                   ecc_done;
  logic                   busy;

  modport slave (
    input  req_valid, req_g, req_k, rsp_ready, ecc_outxa, ecc_outza, ecc_done,
    output req_ready, rsp_valid, rsp_id, rsp_x, rsp_z, rsp_err, ecc_start, ecc_g, ecc_k, busy
  );
  modport master (
    output req_valid, req_g, req_k, rsp_ready, ecc_outxa, ecc_outza, ecc_done,
    input  req_ready, rsp_valid, rsp_id, rsp_x, rsp_z, rsp_err, ecc_start, ecc_g, ecc_k, busy
  );
endinterface

// File: rtl/ecc_rr_arbiter.sv
// Combinational round-robin grant: one-hot winner plus its index.
module ecc_rr_arbiter import ecc_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     win_id
);
  int win;

  always_comb begin
    win = rr_pick(MAX_REQ'(req_valid), 32'(rr_ptr), NUM_REQ);
  end

  assign grant  = (win >= 0) ? (NUM_REQ'(1) << win) : '0;
  assign win_id = IDW'(win);
endmodule

// File: rtl/ecc_req_scheduler.sv
// Shares one ECC scalar-multiply core among NUM_REQ requesters: round-robin grant,
// operand latch, level start held until done or timeout, tagged result on a valid/ready port.
module ecc_req_scheduler import ecc_pkg::*; #(
  parameter int NUM_REQ        = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  ecc_req_scheduler_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state, state_nx;
  logic [IDW-1:0]      rr_ptr, win_id, id_q;
  logic [NUM_REQ-1:0]  grant;
  logic [CW-1:0]       cnt;
  logic [OPW-1:0]      g_q, k_q;
  logic [RESW-1:0]     x_q, z_q;
  logic                err_q, hs, tmo;

  ecc_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req_valid(bus.req_valid), .rr_ptr(rr_ptr), .grant(grant), .win_id(win_id)
  );

  assign hs  = (state == IDLE) && (|grant);
  assign tmo = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs) state_nx = BUSY;
      BUSY:    if (bus.ecc_done || tmo) state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= IDW'(NUM_REQ - 1);
      cnt    <= '0;
      g_q    <= '0;
      k_q    <= '0;
      id_q   <= '0;
      x_q    <= '0;
      z_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (hs) begin
          g_q    <= bus.req_g[win_id*OPW +: OPW];
          k_q    <= bus.req_k[win_id*OPW +: OPW];
          id_q   <= win_id;
          rr_ptr <= win_id;
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          // done takes priority over a coincident timeout
          if (bus.ecc_done) begin
            x_q   <= bus.ecc_outxa;
            z_q   <= bus.ecc_outza;
            err_q <= 1'b0;
          end else if (tmo) begin
            x_q   <= '0;
            z_q   <= '0;
            err_q <= 1'b1;
          end
        end
        RESP: if (bus.rsp_ready) cnt <= '0;
        default: ;
      endcase
    end
  end

  // start and busy decode straight from the state flop so reset drops them at once
  assign bus.req_ready = (state == IDLE) ? grant : '0;
  assign bus.ecc_start = (state == BUSY);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.ecc_g     = g_q;
  assign bus.ecc_k     = k_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_x     = x_q;
  assign bus.rsp_z     = z_q;
  assign bus.rsp_err   = err_q;
endmodule
